// File: rtl/lm70_reader.sv
// ---------------------------------------------------------------------------
// lm70_reader
//   SPI (mode 0) master that reads one frame from an LM70-style temperature
//   sensor per request. CS and SCK are generated from the system clock, SIO
//   is sampled MSB-first on each SCK rising edge, and the completed frame is
//   presented both raw and as the 11-bit signed temperature (0.25 C/LSB).
//
// Ports
//   i_clk        in   system clock, all logic on the rising edge
//   i_reset_n    in   synchronous reset, active low
//   i_start      in   request one frame (only looked at while idle)
//   o_busy       out  high while a frame is in progress (SETUP/SHIFT/HOLD)
//   o_sck        out  serial clock, idles low
//   o_cs         out  chip select, active low, idles high
//   i_sio        in   serial data from the sensor
//   o_temp_raw   out  last completed frame, MSB = first bit received
//   o_temp_q     out  signed temperature, o_temp_raw[NBITS-1 -: 11]
//   o_valid      out  one-cycle pulse while new results are first presented
// ---------------------------------------------------------------------------
module lm70_reader #(
  parameter int CLK_DIV  = 4,   // clk cycles per SCK half-period (>= 2)
  parameter int NBITS    = 16,  // bits per frame (>= 11)
  parameter int CS_SETUP = 2,   // CS low before first SCK rise (>= 1)
  parameter int CS_HOLD  = 2    // CS low after last SCK fall (>= 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_sck,
  output logic             o_cs,
  input  logic             i_sio,
  output logic [NBITS-1:0] o_temp_raw,
  output logic [10:0]      o_temp_q,
  output logic             o_valid
);

  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW   = $clog2(NBITS + 1);
  localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW   = $clog2(PMAX) + 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS);
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [DW-1:0]     r_div_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [PW-1:0]     r_phase;
  logic [NBITS-1:0]  r_shreg;
  logic              r_sck;
  logic [NBITS-1:0]  r_temp_raw;
  logic [10:0]       r_temp_q;

  logic              w_tick;       // SCK toggles at the end of this cycle
  logic              w_sck_rise;   // this tick is a 0->1 transition
  logic              w_last_fall;  // this tick is the final 1->0 transition
  logic              w_hold_end;   // last HOLD cycle, results captured now

  assign w_tick      = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_sck_rise  = w_tick && !r_sck;
  assign w_last_fall = w_tick && r_sck && (r_bit_cnt == BIT_LAST);
  assign w_hold_end  = (r_state == S_HOLD) && (r_phase == HOLD_LAST);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_SETUP;
      S_SETUP: if (r_phase == SETUP_LAST) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last_fall) w_state_next = S_HOLD;
      S_HOLD:  if (r_phase == HOLD_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs
  // -------------------------------------------------------------------------
  always_comb begin
    o_busy  = 1'b0;
    o_cs    = 1'b1;
    o_valid = 1'b0;
    case (r_state)
      S_SETUP, S_SHIFT, S_HOLD: begin
        o_busy = 1'b1;
        o_cs   = 1'b0;
      end
      S_DONE:  o_valid = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: SCK divider, bit counter, setup/hold timer, shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_phase   <= '0;
      r_shreg   <= '0;
      r_sck     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_phase   <= '0;
          r_sck     <= 1'b0;
        end
        S_SETUP: begin
          r_phase <= (r_phase == SETUP_LAST) ? '0 : r_phase + PW'(1);
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            // The sensor changes SIO only after falling edges, so it is
            // stable here and can be taken without a synchronizer.
            if (w_sck_rise) begin
              r_shreg   <= {r_shreg[NBITS-2:0], i_sio};
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_HOLD: begin
          r_phase <= (r_phase == HOLD_LAST) ? '0 : r_phase + PW'(1);
        end
        default: begin
          r_sck <= 1'b0;
        end
      endcase
    end
  end

  // Results load on the HOLD->DONE edge so they are already stable during
  // the valid cycle, and otherwise never move mid-frame.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_temp_raw <= '0;
      r_temp_q   <= '0;
    end else if (w_hold_end) begin
      r_temp_raw <= r_shreg;
      r_temp_q   <= r_shreg[NBITS-1 -: 11];
    end
  end

  assign o_sck      = r_sck;
  assign o_temp_raw = r_temp_raw;
  assign o_temp_q   = r_temp_q;

endmodule

// File: tb/tb_lm70_reader.sv
// ---------------------------------------------------------------------------
// tb_lm70_reader
//   Directed bench for lm70_reader with a behavioural LM70 sensor model and
//   a CS/SCK protocol monitor. Each task drives one scenario and checks its
//   own results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lm70_reader;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start;
  logic        o_busy;
  logic        o_sck;
  logic        o_cs;
  logic        i_sio;
  logic [15:0] o_temp_raw;
  logic [10:0] o_temp_q;
  logic        o_valid;

  int n_cmp = 0;
  int n_bad = 0;

  lm70_reader dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_sck      (o_sck),
    .o_cs       (o_cs),
    .i_sio      (i_sio),
    .o_temp_raw (o_temp_raw),
    .o_temp_q   (o_temp_q),
    .o_valid    (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // -------------------------------------------------------------------------
  // Sensor model: MSB presented when CS falls, next bit after each SCK fall.
  // In alternate mode each new frame takes the next word of alt_vals.
  // -------------------------------------------------------------------------
  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] alt_vals [2] = '{16'h1900, 16'hE700};
  int          alt_idx  = 0;
  bit          alt_mode = 0;
  int          bit_idx  = 15;

  initial i_sio = 1'b0;

  always @(negedge o_cs) begin
    if (alt_mode) begin
      sensor_word = alt_vals[alt_idx];
      alt_idx     = 1 - alt_idx;
    end
    bit_idx = 15;
    i_sio   = sensor_word[bit_idx];
  end

  always @(negedge o_sck) begin
    if (!o_cs && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      i_sio   = sensor_word[bit_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Protocol monitor: per CS-low window record SCK edge counts, the cycle
  // offset of the first SCK rise and the CS hold after the last SCK fall.
  // -------------------------------------------------------------------------
  bit prev_sck  = 0;
  bit in_win    = 0;
  int win_len   = 0;
  int rises     = 0;
  int falls     = 0;
  int first_at  = -1;
  int last_fall = -1;
  int rec_len   = 0;
  int rec_rises = 0;
  int rec_falls = 0;
  int rec_first = 0;
  int rec_hold  = 0;
  int idle_viol = 0;

  always @(negedge i_clk) begin
    if (o_cs === 1'b0) begin
      if (!in_win) begin
        in_win    = 1;
        win_len   = 0;
        rises     = 0;
        falls     = 0;
        first_at  = -1;
        last_fall = -1;
      end
      if (o_sck && !prev_sck) begin
        rises++;
        if (first_at < 0) first_at = win_len;
      end
      if (!o_sck && prev_sck) begin
        falls++;
        last_fall = win_len;
      end
      win_len++;
    end else begin
      if (o_sck === 1'b1) idle_viol++;
      if (in_win) begin
        in_win    = 0;
        rec_len   = win_len;
        rec_rises = rises;
        rec_falls = falls;
        rec_first = first_at;
        rec_hold  = win_len - last_fall;
      end
    end
    prev_sck = (o_sck === 1'b1);
  end

  // Stimulus helper: pulse start for one cycle, return the cycle in which
  // valid is seen (1 = first cycle after the accepting edge), -1 on timeout.
  task automatic run_frame(output int lat);
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_valid && lat < 400) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_valid) lat = -1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_cs !== 1'b1)   begin n_bad++; $display("FAIL reset_cs: got %b want 1", o_cs); end
    n_cmp++; if (o_sck !== 1'b0)  begin n_bad++; $display("FAIL reset_sck: got %b want 0", o_sck); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_temp_raw !== 16'h0000) begin n_bad++; $display("FAIL reset_raw: got %h want 0000", o_temp_raw); end
    n_cmp++; if (o_temp_q !== 11'h000) begin n_bad++; $display("FAIL reset_q: got %h want 000", o_temp_q); end
    i_reset_n = 1'b1;
    @(negedge i_clk);
    $display("reset: cs=%b sck=%b busy=%b raw=%h", o_cs, o_sck, o_busy, o_temp_raw);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    int lat;
    sensor_word = 16'h4400;
    run_frame(lat);
    $display("frame 4400: latency=%0d raw=%h q=%h", lat, o_temp_raw, o_temp_q);
    n_cmp++; if (lat != 133) begin n_bad++; $display("FAIL basic_latency: got %0d want 133", lat); end
    n_cmp++; if (o_temp_raw !== 16'h4400) begin n_bad++; $display("FAIL basic_raw: got %h want 4400", o_temp_raw); end
    n_cmp++; if (o_temp_q !== 11'h220) begin n_bad++; $display("FAIL basic_q: got %h want 220", o_temp_q); end
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_pulse: got %b want 0", o_valid); end
    n_cmp++; if (o_temp_raw !== 16'h4400) begin n_bad++; $display("FAIL basic_raw_hold: got %h want 4400", o_temp_raw); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_sign();
    int lat;
    sensor_word = 16'hFFE0;
    run_frame(lat);
    $display("frame FFE0: latency=%0d raw=%h q=%h", lat, o_temp_raw, o_temp_q);
    n_cmp++; if (o_temp_raw !== 16'hFFE0) begin n_bad++; $display("FAIL neg_raw: got %h want ffe0", o_temp_raw); end
    n_cmp++; if (o_temp_q !== 11'h7FF) begin n_bad++; $display("FAIL neg_q: got %h want 7ff", o_temp_q); end
    sensor_word = 16'h0000;
    run_frame(lat);
    $display("frame 0000: latency=%0d raw=%h q=%h", lat, o_temp_raw, o_temp_q);
    n_cmp++; if (o_temp_raw !== 16'h0000) begin n_bad++; $display("FAIL zero_raw: got %h want 0000", o_temp_raw); end
    n_cmp++; if (o_temp_q !== 11'h000) begin n_bad++; $display("FAIL zero_q: got %h want 000", o_temp_q); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_protocol();
    int lat;
    sensor_word = 16'hA5C3;
    run_frame(lat);
    @(negedge i_clk);
    $display("protocol: len=%0d rises=%0d falls=%0d first=%0d hold=%0d viol=%0d raw=%h",
             rec_len, rec_rises, rec_falls, rec_first, rec_hold, idle_viol, o_temp_raw);
    n_cmp++; if (o_temp_raw !== 16'hA5C3) begin n_bad++; $display("FAIL proto_raw: got %h want a5c3", o_temp_raw); end
    n_cmp++; if (o_temp_q !== 11'h52E) begin n_bad++; $display("FAIL proto_q: got %h want 52e", o_temp_q); end
    n_cmp++; if (rec_rises != 16) begin n_bad++; $display("FAIL proto_rises: got %0d want 16", rec_rises); end
    n_cmp++; if (rec_falls != 16) begin n_bad++; $display("FAIL proto_falls: got %0d want 16", rec_falls); end
    n_cmp++; if (rec_first != 6) begin n_bad++; $display("FAIL proto_setup: got %0d want 6", rec_first); end
    n_cmp++; if (rec_hold != 2) begin n_bad++; $display("FAIL proto_hold: got %0d want 2", rec_hold); end
    n_cmp++; if (rec_len != 132) begin n_bad++; $display("FAIL proto_cs_len: got %0d want 132", rec_len); end
    n_cmp++; if (idle_viol != 0) begin n_bad++; $display("FAIL proto_sck_idle: got %0d want 0", idle_viol); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_ignore_start();
    int valids   = 0;
    int valid_at = -1;
    int breaks   = 0;
    int extra    = 0;
    sensor_word = 16'h2A60;
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      if (o_valid) begin valids++; valid_at = c; end
      if (c <= 132 && !o_busy) breaks++;
      if (c >= 134 && o_busy) extra++;
      i_start = (c == 9 || c == 59);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    $display("ignore_start: valids=%0d at=%0d breaks=%0d extra=%0d raw=%h", valids, valid_at, breaks, extra, o_temp_raw);
    n_cmp++; if (valids != 1) begin n_bad++; $display("FAIL ign_valids: got %0d want 1", valids); end
    n_cmp++; if (valid_at != 133) begin n_bad++; $display("FAIL ign_valid_at: got %0d want 133", valid_at); end
    n_cmp++; if (breaks != 0) begin n_bad++; $display("FAIL ign_busy_gap: got %0d want 0", breaks); end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ign_second_frame: got %0d want 0", extra); end
    n_cmp++; if (o_temp_raw !== 16'h2A60) begin n_bad++; $display("FAIL ign_raw: got %h want 2a60", o_temp_raw); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_abort();
    int lat;
    int valids = 0;
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    sensor_word = 16'h4400;
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (68) @(negedge i_clk);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    $display("abort: cs=%b sck=%b busy=%b valid=%b raw=%h", o_cs, o_sck, o_busy, o_valid, o_temp_raw);
    n_cmp++; if (o_cs !== 1'b1) begin n_bad++; $display("FAIL abort_cs: got %b want 1", o_cs); end
    n_cmp++; if (o_sck !== 1'b0) begin n_bad++; $display("FAIL abort_sck: got %b want 0", o_sck); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_temp_raw !== 16'h0000) begin n_bad++; $display("FAIL abort_raw: got %h want 0000", o_temp_raw); end
    i_reset_n = 1'b1;
    for (int c = 0; c < 140; c++) begin
      if (o_valid || o_busy) valids++;
      @(negedge i_clk);
    end
    n_cmp++; if (valids != 0) begin n_bad++; $display("FAIL abort_no_activity: got %0d want 0", valids); end
    run_frame(lat);
    $display("after abort: latency=%0d raw=%h q=%h", lat, o_temp_raw, o_temp_q);
    n_cmp++; if (lat != 133) begin n_bad++; $display("FAIL abort_relatency: got %0d want 133", lat); end
    n_cmp++; if (o_temp_raw !== 16'h4400) begin n_bad++; $display("FAIL abort_reread: got %h want 4400", o_temp_raw); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    int          at   [3];
    logic [15:0] raw  [3];
    logic [10:0] q    [3];
    logic [15:0] want_raw [3];
    logic [10:0] want_q   [3];
    int nv   = 0;
    int gap  = 0;
    int wait_c = 0;
    want_raw = '{16'h1900, 16'hE700, 16'h1900};
    want_q   = '{11'h0C8, 11'h738, 11'h0C8};
    for (int k = 0; k < 3; k++) begin at[k] = -1; raw[k] = '0; q[k] = '0; end
    alt_idx  = 0;
    alt_mode = 1;
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    for (int c = 1; c <= 600 && nv < 3; c++) begin
      if (o_valid) begin
        at[nv] = c; raw[nv] = o_temp_raw; q[nv] = o_temp_q; nv++;
      end
      if (nv == 1 && !o_busy) gap++;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      $display("b2b frame %0d: at=%0d raw=%h q=%h", k, at[k], raw[k], q[k]);
      n_cmp++; if (raw[k] !== want_raw[k]) begin n_bad++; $display("FAIL b2b_raw%0d: got %h want %h", k, raw[k], want_raw[k]); end
      n_cmp++; if (q[k] !== want_q[k]) begin n_bad++; $display("FAIL b2b_q%0d: got %h want %h", k, q[k], want_q[k]); end
      n_cmp++; if (at[k] != 133 + 134 * k) begin n_bad++; $display("FAIL b2b_at%0d: got %0d want %0d", k, at[k], 133 + 134 * k); end
    end
    // DONE plus one IDLE cycle are the only non-busy cycles between frames
    n_cmp++; if (gap != 2) begin n_bad++; $display("FAIL b2b_idle_gap: got %0d want 2", gap); end
    while ((o_busy || o_valid) && wait_c < 300) begin
      @(negedge i_clk);
      wait_c++;
    end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got busy=%b want 0", o_busy); end
    alt_mode = 0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    test_reset();
    test_basic();
    test_sign();
    test_protocol();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
